// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the two-line sequence generator.
// Holds the pattern table (time offset in units and {i1,i2} level for each
// of the 12 steps a..l), the step index type, and the generator state enum.
package fsm_seq_pkg;

    localparam int NUM_STEPS = 12;
    localparam int END_TIME  = 4500;   // time of the last step (l)
    localparam int TIME_W    = 13;     // wide enough for every STEP_TIME entry

    typedef logic [3:0] step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } gen_state_t;

    localparam logic [TIME_W-1:0] STEP_TIME [NUM_STEPS] = '{
        13'd0,    13'd500,  13'd1000, 13'd1500,
        13'd2000, 13'd2300, 13'd2800, 13'd3000,
        13'd3300, 13'd3500, 13'd4000, 13'd4500
    };

    // {i1,i2}; consecutive entries differ in exactly one line.
    localparam logic [1:0] STEP_LEVEL [NUM_STEPS] = '{
        2'b00, 2'b10, 2'b11, 2'b01,
        2'b00, 2'b10, 2'b11, 2'b01,
        2'b00, 2'b01, 2'b11, 2'b01
    };

    // Guarded lookups: indices past the table read as zero.
    function automatic logic [TIME_W-1:0] step_time(input step_t idx);
        return (int'(idx) < NUM_STEPS) ? STEP_TIME[idx] : '0;
    endfunction

    function automatic logic [1:0] step_level(input step_t idx);
        return (int'(idx) < NUM_STEPS) ? STEP_LEVEL[idx] : 2'b00;
    endfunction

endpackage

// File: rtl/seq_unit_tick.sv
// Unit prescaler: counts 0..UNIT_CYCLES-1 and raises tick_o during the
// cycle in which the count sits at its last value, so each wrap edge is
// one time unit. At UNIT_CYCLES=1 the count is stuck at 0 and the tick is
// constantly high.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   asynchronous active-high reset
//   clr_i   synchronous clear of the count (held while the generator idles)
//   tick_o  unit tick
module seq_unit_tick #(
    parameter int UNIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] cnt_q;

    assign tick_o = (cnt_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/fsm_seq_gen.sv
// Stimulus generator for the two-line (i1/i2) sequence detector.
// On an accepted start it walks the 12-step pattern at the tabled unit
// offsets, holds the last level for TAIL_UNITS units, then drops both lines
// and pulses done.
// Handshake: start is a level sampled only in IDLE (ignored if abort is also
// high); busy is high from the accepting edge until the run ends; done is a
// single-cycle pulse on normal completion only; abort ends a run on the next
// edge without done and wins over any step advance or tail expiry.
// Ports:
//   clk, reset        clock (rising) and async active-high reset
//   start, abort      run control levels
//   i1, i2            registered sequence lines
//   busy, done, step  run status; step is the pattern index (0 in IDLE)
//   dbg_state_o       current generator state
module fsm_seq_gen
    import fsm_seq_pkg::*;
#(
    parameter int UNIT_CYCLES = 1,
    parameter int TAIL_UNITS  = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic       i1,
    output logic       i2,
    output logic       busy,
    output logic       done,
    output logic [3:0] step,
    output gen_state_t dbg_state_o
);

    localparam int TW = $clog2(END_TIME + TAIL_UNITS + 1);
    localparam logic [TW-1:0] FINISH_T = TW'(END_TIME + TAIL_UNITS);

    gen_state_t    state_q;
    logic [TW-1:0] t_q, t_d;
    step_t         step_q, step_d;
    logic [1:0]    level_q;
    logic          busy_q, done_q;
    logic          tick;
    logic          prescale_clr;

    // Keeping the prescaler cleared through IDLE means it is also zero
    // right after the accepting edge.
    assign prescale_clr = (state_q == IDLE);

    seq_unit_tick #(.UNIT_CYCLES(UNIT_CYCLES)) u_tick (
        .clk_i  (clk),
        .rst_i  (reset),
        .clr_i  (prescale_clr),
        .tick_o (tick)
    );

    // t_d is the unit count as of the coming edge, so a step whose time is
    // reached changes level on that same edge.
    always_comb begin
        t_d    = t_q + TW'(tick);
        step_d = step_q + 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            t_q     <= '0;
            step_q  <= '0;
            level_q <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= RUN;
                        t_q     <= '0;
                        step_q  <= '0;
                        level_q <= STEP_LEVEL[0];
                        busy_q  <= 1'b1;
                    end
                end
                RUN, TAIL: begin
                    if (abort) begin
                        state_q <= IDLE;
                        t_q     <= '0;
                        step_q  <= '0;
                        level_q <= 2'b00;
                        busy_q  <= 1'b0;
                    end else begin
                        t_q <= t_d;
                        if (state_q == RUN) begin
                            if (tick && t_d == TW'(step_time(step_d))) begin
                                step_q  <= step_d;
                                level_q <= step_level(step_d);
                                if (step_d == step_t'(NUM_STEPS - 1)) begin
                                    state_q <= TAIL;
                                end
                            end
                        end else if (tick && t_d == FINISH_T) begin
                            state_q <= IDLE;
                            t_q     <= '0;
                            step_q  <= '0;
                            level_q <= 2'b00;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i1          = level_q[1];
    assign i2          = level_q[0];
    assign busy        = busy_q;
    assign done        = done_q;
    assign step        = step_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Bench for fsm_seq_gen: two instances (UNIT_CYCLES=1 and 4) share the
// control inputs; a monitor compares the selected instance's outputs
// against a queue of timed expectations built from the pattern table.
module tb_fsm_seq_gen;
    import fsm_seq_pkg::*;

    localparam int EW = 40;   // {target cycle[31:0], lvl[1:0], step[3:0], busy, done}

    typedef struct {
        int         t_units;
        logic [1:0] lvl;
        logic [3:0] stp;
        logic       bsy;
        logic       dn;
    } vec_t;

    vec_t tbl [13];

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       i1_a, i2_a, busy_a, done_a;
    logic [3:0] step_a;
    gen_state_t st_a;
    logic       i1_b, i2_b, busy_b, done_b;
    logic [3:0] step_b;
    gen_state_t st_b;

    fsm_seq_gen #(.UNIT_CYCLES(1), .TAIL_UNITS(500)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .i1(i1_a), .i2(i2_a), .busy(busy_a), .done(done_a),
        .step(step_a), .dbg_state_o(st_a)
    );

    fsm_seq_gen #(.UNIT_CYCLES(4), .TAIL_UNITS(500)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .i1(i1_b), .i2(i2_b), .busy(busy_b), .done(done_b),
        .step(step_b), .dbg_state_o(st_b)
    );

    logic       sel_b = 1'b0;
    logic [1:0] m_lvl;
    logic [3:0] m_step;
    logic       m_busy, m_done;
    gen_state_t m_st;
    assign m_lvl  = sel_b ? {i1_b, i2_b} : {i1_a, i2_a};
    assign m_step = sel_b ? step_b : step_a;
    assign m_busy = sel_b ? busy_b : busy_a;
    assign m_done = sel_b ? done_b : done_a;
    assign m_st   = sel_b ? st_b : st_a;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_vec       = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    task automatic push(input int target, input logic [1:0] lvl, input logic [3:0] stp,
                        input logic bsy, input logic dn);
        exp_q.push_back({32'(target), lvl, stp, bsy, dn});
    endtask

    // Expectations for a run accepted at edge s: the level at each step edge
    // and the previous level one cycle earlier, up to table entry 'last'.
    task automatic push_run(input int s, input int uc, input int last, input logic held);
        for (int i = 0; i <= last; i++) begin
            if (i > 0)
                push(s + tbl[i].t_units * uc - 1, tbl[i-1].lvl, tbl[i-1].stp, tbl[i-1].bsy, tbl[i-1].dn);
            push(s + tbl[i].t_units * uc, tbl[i].lvl, tbl[i].stp, tbl[i].bsy, tbl[i].dn);
        end
        if (last == 12)
            push(s + tbl[12].t_units * uc + 1, 2'b00, 4'd0, held, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [7:0]    got;
        if (m_done) done_cnt++;
        while (exp_q.size() > 0 && int'(exp_q[0][39:8]) <= cyc) begin
            e   = exp_q.pop_front();
            got = {m_lvl, m_step, m_busy, m_done};
            n_vec++;
            if (int'(e[39:8]) != cyc || got !== e[7:0]) begin
                miscompares++;
                $display("FAIL vec@%0d (now %0d): got lvl=%b step=%0d busy=%b done=%b, want lvl=%b step=%0d busy=%b done=%b",
                         int'(e[39:8]), cyc, got[7:6], got[5:2], got[1], got[0],
                         e[7:6], e[5:2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d expectations left after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    // Raises start at a negedge; the next rising edge accepts it.
    task automatic begin_start(output int s);
        @(negedge clk);
        s     = cyc + 1;
        start = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start_at(input int edge_n);
        wait_cyc(edge_n - 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abort_at(input int edge_n);
        wait_cyc(edge_n - 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // ---------------- test ----------------
    initial begin
        int s, s2, d0;

        tbl[0]  = '{0,    2'b00, 4'd0,  1'b1, 1'b0};
        tbl[1]  = '{500,  2'b10, 4'd1,  1'b1, 1'b0};
        tbl[2]  = '{1000, 2'b11, 4'd2,  1'b1, 1'b0};
        tbl[3]  = '{1500, 2'b01, 4'd3,  1'b1, 1'b0};
        tbl[4]  = '{2000, 2'b00, 4'd4,  1'b1, 1'b0};
        tbl[5]  = '{2300, 2'b10, 4'd5,  1'b1, 1'b0};
        tbl[6]  = '{2800, 2'b11, 4'd6,  1'b1, 1'b0};
        tbl[7]  = '{3000, 2'b01, 4'd7,  1'b1, 1'b0};
        tbl[8]  = '{3300, 2'b00, 4'd8,  1'b1, 1'b0};
        tbl[9]  = '{3500, 2'b01, 4'd9,  1'b1, 1'b0};
        tbl[10] = '{4000, 2'b11, 4'd10, 1'b1, 1'b0};
        tbl[11] = '{4500, 2'b01, 4'd11, 1'b1, 1'b0};
        tbl[12] = '{5000, 2'b00, 4'd0,  1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_lines", 32'(m_lvl), 32'd0);
        chk("rst_busy",  32'(m_busy), 32'd0);
        chk("rst_done",  32'(m_done), 32'd0);
        chk("rst_step",  32'(m_step), 32'd0);
        chk("rst_state", 32'(m_st), 32'(IDLE));
        reset = 1'b0;
        @(negedge clk);

        // start together with abort in IDLE is ignored
        start = 1'b1;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_abort_idle_busy", 32'(m_busy), 32'd0);
        start = 1'b0;
        abort = 1'b0;

        // Full run, UNIT_CYCLES=1
        begin_start(s);
        push_run(s, 1, 12, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        wait_drain(5200);
        chk("full_done_once", 32'(done_cnt - d0), 32'd1);

        // Abort at step 4 (level 00)
        begin_start(s);
        push_run(s, 1, 4, 1'b0);
        push(s + 2099, 2'b00, 4'd4, 1'b1, 1'b0);
        push(s + 2100, 2'b00, 4'd0, 1'b0, 1'b0);
        push(s + 2101, 2'b00, 4'd0, 1'b0, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        abort_at(s + 2100);
        wait_drain(300);
        wait_cyc(s + 5100);
        chk("abort1_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort1_idle_busy", 32'(m_busy), 32'd0);

        // Abort at level 11
        begin_start(s);
        push_run(s, 1, 6, 1'b0);
        push(s + 2899, 2'b11, 4'd6, 1'b1, 1'b0);
        push(s + 2900, 2'b00, 4'd0, 1'b0, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        abort_at(s + 2900);
        wait_drain(300);
        chk("abort2_no_done", 32'(done_cnt - d0), 32'd0);

        // Abort exactly on a step edge wins over the advance
        begin_start(s);
        push(s + 499, 2'b00, 4'd0, 1'b1, 1'b0);
        push(s + 500, 2'b00, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        abort_at(s + 500);
        wait_drain(300);

        // start re-pulsed during the run is ignored
        begin_start(s);
        push_run(s, 1, 12, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        pulse_start_at(s + 300);
        pulse_start_at(s + 4600);
        wait_drain(5200);
        chk("repulse_done_once", 32'(done_cnt - d0), 32'd1);

        // Asynchronous reset mid-run at level 11
        begin_start(s);
        push_run(s, 1, 2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_cyc(s + 1199);
        chk("pre_reset_lines", 32'(m_lvl), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_lines", 32'({i1_a, i2_a}), 32'd0);
        chk("async_rst_busy",  32'(busy_a), 32'd0);
        chk("async_rst_step",  32'(step_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_drain(10);
        begin_start(s);
        push_run(s, 1, 12, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_drain(5200);

        // start held high: back-to-back runs with one IDLE cycle
        begin_start(s);
        push_run(s, 1, 12, 1'b1);
        s2 = s + 5001;
        push_run(s2, 1, 12, 1'b0);
        d0 = done_cnt;
        wait_cyc(s2 + 100);
        start = 1'b0;
        wait_drain(5200);
        chk("held_two_dones", 32'(done_cnt - d0), 32'd2);

        // UNIT_CYCLES=4 instance
        pulse_reset();
        sel_b = 1'b1;
        chk("uc4_rst_busy", 32'(m_busy), 32'd0);
        begin_start(s);
        push_run(s, 4, 12, 1'b0);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b0;
        wait_drain(20200);
        chk("uc4_done_once", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

    // Overall time bound
    initial begin
        #3_000_000;
        miscompares++;
        $display("FAIL watchdog: bench still running at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_seq_gen.md
# fsm_seq_gen

Stimulus generator for the two-line handshake sequence consumed by the `FSM` sequence detector. It drives `i1`/`i2` through the fixed 12-state pattern (a..l) at the programmed time offsets. It then returns both lines low and reports completion. It sits upstream of the detector in the same clock domain and also serves as the bench-side driver for that detector.

## Interface
- `UNIT_CYCLES`, default 1: clock cycles per time unit. Must be ≥1. At 1 the prescaler is a constant tick.
- `TAIL_UNITS`, default 500: units to hold the final level (state l) before returning to idle. Must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  level; sampled only in IDLE; begins a run.
- `abort`  in  1  level; terminates a run, no `done`.
- `i1`  out  1  sequence line 1, registered.
- `i2`  out  1  sequence line 2, registered.
- `busy`  out  1  high for the whole run.
- `done`  out  1  one-cycle pulse at normal completion.
- `step`  out  4  current pattern index 0..11 (a=0 .. l=11); 0 in IDLE.

## Operation
- Pattern table, index: time in units, `{i1,i2}` level:
  - 0:0 00, 1:500 10, 2:1000 11, 3:1500 01
  - 4:2000 00, 5:2300 10, 6:2800 11, 7:3000 01
  - 8:3300 00, 9:3500 01, 10:4000 11, 11:4500 01
- Each step changes exactly one line, matching the detector's transition conditions.
- States:
  - IDLE: `i1`=`i2`=0, `busy`=0, `step`=0.
    - `start`=1 and `abort`=0 → RUN. Time counter and prescaler are cleared, `step`=0, `busy`=1 from that edge.
  - RUN: the prescaler counts 0..UNIT_CYCLES-1, and each wrap increments the unit counter `t`.
    - When `t` reaches STEP_TIME[step+1], `step` advances and `{i1,i2}` takes the new level on the same edge.
  - After step 11, hold for TAIL_UNITS units. Then, on one edge: `{i1,i2}`=00, `done`=1, `busy`=0, `step`=0, and the block returns to IDLE.
- `abort`=1 sampled in RUN → next edge `{i1,i2}`=00, `busy`=0, `step`=0, `done` stays 0, IDLE.
  - `abort` has priority over step advance and tail expiry on the same edge.
- `start` during RUN is ignored, as is `start`=1 with `abort`=1 in IDLE.
- `start` held high continuously → a new run begins on the edge after `done`. Runs are back-to-back with one IDLE cycle.

## Timing
- Let S be the edge at which `start` is accepted. `{i1,i2}`=STEP_LEVEL[k] from edge S + STEP_TIME[k]·UNIT_CYCLES.
- Completion edge: S + (4500+TAIL_UNITS)·UNIT_CYCLES. `done` is high for exactly that one cycle.
- The `step` update and the output level change occur on the same edge, with zero skew between them.
- Outputs are registered, with no combinational path from inputs to outputs.
- Unit counter width: clog2(4500+TAIL_UNITS+1), which is 13 bits at the defaults. It never wraps, because it is cleared at start and RUN ends first.
- Prescaler width: max(1, clog2(UNIT_CYCLES)).
- Reset (async assert, sync-safe release): `i1`=0, `i2`=0, `busy`=0, `done`=0, `step`=0, state IDLE, counters 0.
  - Reset mid-run drops the lines immediately, with no `done`.

## Structure
- Package `fsm_seq_pkg`:
  - NUM_STEPS=12
  - `step_t` (4-bit)
  - `gen_state_t` enum {IDLE, RUN, TAIL}
  - STEP_TIME[12] and STEP_LEVEL[12] (2-bit `{i1,i2}`) constant arrays
  - END_TIME=4500
- Sub-module `seq_unit_tick`: prescaler producing a one-cycle unit tick, with a synchronous clear, parameterised by UNIT_CYCLES.
- Top module: state register, unit counter, step index, output registers.

## Test plan
- Full run, UNIT_CYCLES=1: pulse `start` at S.
  - Edges with the level after each edge: S+500 10, S+1000 11, S+1500 01, S+2000 00, S+2300 10, S+2800 11, S+3000 01, S+3300 00, S+3500 01, S+4000 11, S+4500 01.
  - At S+5000: 00, `done`=1 for one cycle, `busy`=0.
  - The detector connected downstream reaches state l.
- UNIT_CYCLES=4: first transition at S+2000 (10), final level at S+18000, `done` at S+20000.
- `abort` sampled at S+2100 (level 00, step 4) → that edge: `busy`=0, `step`=0, no `done`, lines stay 00.
  - Repeat at S+2900 (level 11) → lines drop to 00.
- `start` re-pulsed at S+300 and S+4600 → no restart; timing identical to the full run.
- `reset` asserted asynchronously at S+1200 (level 11) → `i1`=`i2`=0, `busy`=0 immediately, without waiting for an edge.
  - After release, `start` produces a clean run.
- `start` held high → second run's first transition at S+5001+500; `done` pulses once per run.
